aes_job_arbiter: RTL and testbench

AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

---
 rtl/aes_job_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_aes_job_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_arbiter.sv
// Two-requester round-robin front end for a single AES engine: latches a job, runs it, holds the result.
// Optional watchdog in RUN is built only when AES_TIMEOUT_EN is defined.
module aes_job_arbiter #(
   parameter int Nk             = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk_master,
   input  logic                rst,
   input  logic                req0,
   input  logic                req1,
   input  logic                mode0,
   input  logic                mode1,
   input  logic [127:0]        data0,
   input  logic [127:0]        data1,
   input  logic [Nk*32-1:0]    key0,
   input  logic [Nk*32-1:0]    key1,
   output logic                gnt0,
   output logic                gnt1,
   output logic                rsp_valid,
   output logic                rsp_id,
   output logic [127:0]        rsp_data,
   output logic                rsp_err,
   input  logic                rsp_ready,
   output logic                eng_rst,
   output logic                eng_sel_encrypt,
   output logic                eng_sel_decrypt,
   output logic [127:0]        eng_data,
   output logic [Nk*32-1:0]    eng_key,
   input  logic                eng_done,
   input  logic [127:0]        eng_data_out
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t             state_reg, state_next;
   logic               ptr_reg, ptr_next;
   logic               gnt0_reg, gnt0_next;
   logic               gnt1_reg, gnt1_next;
   logic               rsp_valid_reg, rsp_valid_next;
   logic               rsp_id_reg, rsp_id_next;
   logic [127:0]       rsp_data_reg, rsp_data_next;
   logic               eng_rst_reg, eng_rst_next;
   logic               sel_enc_reg, sel_enc_next;
   logic               sel_dec_reg, sel_dec_next;
   logic [127:0]       eng_data_reg, eng_data_next;
   logic [Nk*32-1:0]   eng_key_reg, eng_key_next;
   logic               win_id;
   logic               win_mode;

`ifdef AES_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0]    wd_reg, wd_next;
   logic               rsp_err_reg, rsp_err_next;
`endif

   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      gnt0_next      = 1'b0;
      gnt1_next      = 1'b0;
      rsp_valid_next = rsp_valid_reg;
      rsp_id_next    = rsp_id_reg;
      rsp_data_next  = rsp_data_reg;
      eng_rst_next   = eng_rst_reg;
      sel_enc_next   = sel_enc_reg;
      sel_dec_next   = sel_dec_reg;
      eng_data_next  = eng_data_reg;
      eng_key_next   = eng_key_reg;
`ifdef AES_TIMEOUT_EN
      wd_next        = wd_reg;
      rsp_err_next   = rsp_err_reg;
`endif
      // Pointer only matters on a tie; a lone requester always wins.
      win_id   = req1 & (~req0 | ptr_reg);
      win_mode = win_id ? mode1 : mode0;

      case (state_reg)
         IDLE: begin
            eng_rst_next   = 1'b1;
            sel_enc_next   = 1'b0;
            sel_dec_next   = 1'b0;
            rsp_valid_next = 1'b0;
            if (req0 | req1) begin
               state_next    = LOAD;
               gnt0_next     = ~win_id;
               gnt1_next     = win_id;
               ptr_next      = ~win_id;
               rsp_id_next   = win_id;
               sel_enc_next  = win_mode;
               sel_dec_next  = ~win_mode;
               eng_data_next = win_id ? data1 : data0;
               eng_key_next  = win_id ? key1 : key0;
            end
         end
         LOAD: begin
            state_next   = RUN;
            eng_rst_next = 1'b0;
`ifdef AES_TIMEOUT_EN
            wd_next      = '0;
`endif
         end
         RUN: begin
            if (eng_done) begin
               state_next     = RESP;
               rsp_data_next  = eng_data_out;
               rsp_valid_next = 1'b1;
               eng_rst_next   = 1'b1;
               sel_enc_next   = 1'b0;
               sel_dec_next   = 1'b0;
`ifdef AES_TIMEOUT_EN
               rsp_err_next   = 1'b0;
            end else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
               // This is the last permitted RUN cycle; abort with an error response.
               state_next     = RESP;
               rsp_data_next  = '0;
               rsp_err_next   = 1'b1;
               rsp_valid_next = 1'b1;
               eng_rst_next   = 1'b1;
               sel_enc_next   = 1'b0;
               sel_dec_next   = 1'b0;
            end else begin
               wd_next = wd_reg + 1'b1;
`endif
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next     = IDLE;
               rsp_valid_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_master or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= 1'b0;
         gnt0_reg      <= 1'b0;
         gnt1_reg      <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= 1'b0;
         rsp_data_reg  <= '0;
         eng_rst_reg   <= 1'b1;
         sel_enc_reg   <= 1'b0;
         sel_dec_reg   <= 1'b0;
         eng_data_reg  <= '0;
         eng_key_reg   <= '0;
`ifdef AES_TIMEOUT_EN
         wd_reg        <= '0;
         rsp_err_reg   <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         gnt0_reg      <= gnt0_next;
         gnt1_reg      <= gnt1_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_id_reg    <= rsp_id_next;
         rsp_data_reg  <= rsp_data_next;
         eng_rst_reg   <= eng_rst_next;
         sel_enc_reg   <= sel_enc_next;
         sel_dec_reg   <= sel_dec_next;
         eng_data_reg  <= eng_data_next;
         eng_key_reg   <= eng_key_next;
`ifdef AES_TIMEOUT_EN
         wd_reg        <= wd_next;
         rsp_err_reg   <= rsp_err_next;
`endif
      end
   end

   assign gnt0            = gnt0_reg;
   assign gnt1            = gnt1_reg;
   assign rsp_valid       = rsp_valid_reg;
   assign rsp_id          = rsp_id_reg;
   assign rsp_data        = rsp_data_reg;
   assign eng_rst         = eng_rst_reg;
   assign eng_sel_encrypt = sel_enc_reg;
   assign eng_sel_decrypt = sel_dec_reg;
   assign eng_data        = eng_data_reg;
   assign eng_key         = eng_key_reg;
`ifdef AES_TIMEOUT_EN
   assign rsp_err         = rsp_err_reg;
`else
   assign rsp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Scoreboard bench for aes_job_arbiter with a behavioural engine stand-in.
// Define AES_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_aes_job_arbiter;
   localparam int NK  = 4;
   localparam int KW  = NK * 32;
   localparam int LAT = 5;
   localparam logic [127:0] VEC_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] VEC_D = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] VEC_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk_master = 1'b0;
   always #5 clk_master = ~clk_master;

   logic          rst, req0, req1, mode0, mode1, rsp_ready;
   logic [127:0]  data0, data1;
   logic [KW-1:0] key0, key1;
   logic          gnt0, gnt1, rsp_valid, rsp_id, rsp_err;
   logic [127:0]  rsp_data;
   logic          eng_rst, eng_sel_encrypt, eng_sel_decrypt, eng_done;
   logic [127:0]  eng_data, eng_data_out;
   logic [KW-1:0] eng_key;

   logic          model_done, stray_done, eng_hang;
   logic [7:0]    eng_cnt;

   typedef struct packed {logic id; logic [127:0] data; logic err;} rsp_t;
   rsp_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   aes_job_arbiter #(.Nk(NK), .TIMEOUT_CYCLES(16)) dut (
      .clk_master(clk_master), .rst(rst),
      .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
      .data0(data0), .data1(data1), .key0(key0), .key1(key1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready),
      .eng_rst(eng_rst), .eng_sel_encrypt(eng_sel_encrypt), .eng_sel_decrypt(eng_sel_decrypt),
      .eng_data(eng_data), .eng_key(eng_key), .eng_done(eng_done), .eng_data_out(eng_data_out)
   );

   // Engine stand-in: the known AES-128 vector, otherwise a cheap mode-dependent mix.
   function automatic logic [127:0] eng_fn(input logic [127:0] d, input logic [127:0] k, input logic enc);
      if (enc && d == VEC_D && k == VEC_K) return VEC_C;
      if (enc) return {d[95:0], d[127:96]} ^ k;
      return ~(d ^ {k[63:0], k[127:64]});
   endfunction

   assign eng_data_out = eng_fn(eng_data, eng_key, eng_sel_encrypt);
   assign eng_done     = model_done | stray_done;

   always @(posedge clk_master) begin
      if (eng_rst) begin
         eng_cnt    <= 8'd0;
         model_done <= 1'b0;
      end else begin
         model_done <= !eng_hang && (eng_cnt == 8'(LAT - 1));
         if (eng_cnt != 8'hFF) eng_cnt <= eng_cnt + 8'd1;
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk_master);
      vectors++;
      if ({gnt0, gnt1, rsp_valid, rsp_err, rsp_id} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 00000", {gnt0, gnt1, rsp_valid, rsp_err, rsp_id});
      end
      vectors++;
      if ({eng_rst, eng_sel_encrypt, eng_sel_decrypt} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_eng_ctl got %b want 100", {eng_rst, eng_sel_encrypt, eng_sel_decrypt});
      end
      vectors++;
      if (rsp_data !== 128'h0 || eng_data !== 128'h0 || eng_key !== '0) begin
         miscompares++;
         $display("FAIL reset_buses got rsp=%h eng_data=%h eng_key=%h want 0", rsp_data, eng_data, eng_key);
      end
      rst = 1'b0;
      @(negedge clk_master);
   endtask

   task automatic test_round_robin();
      logic [127:0] d0[2], d1[2], k0[2], k1[2];
      int gq[$];
      int p, left0, left1, w, n0, n1, got, cyc, g;
      rsp_t e;
      for (int i = 0; i < 2; i++) begin
         d0[i] = rnd128(); d1[i] = rnd128(); k0[i] = rnd128(); k1[i] = rnd128();
      end
      p = 0; left0 = 2; left1 = 2;
      for (int i = 0; i < 4; i++) begin
         w = (left0 > 0 && left1 > 0) ? p : ((left0 > 0) ? 0 : 1);
         gq.push_back(w);
         if (w == 0) begin
            exp_q.push_back('{1'b0, eng_fn(d0[2-left0], k0[2-left0], 1'b1), 1'b0});
            left0--;
         end else begin
            exp_q.push_back('{1'b1, eng_fn(d1[2-left1], k1[2-left1], 1'b0), 1'b0});
            left1--;
         end
         p = 1 - w;
      end
      mode0 = 1'b1; mode1 = 1'b0; rsp_ready = 1'b1;
      req0 = 1'b1; data0 = d0[0]; key0 = k0[0];
      req1 = 1'b1; data1 = d1[0]; key1 = k1[0];
      n0 = 0; n1 = 0; got = 0; cyc = 0;
      while (got < 4 && cyc < 400) begin
         @(negedge clk_master);
         cyc++;
         if (gnt0 && gnt1) begin
            vectors++; miscompares++;
            $display("FAIL rr_both_gnt got gnt0=1 gnt1=1 want at most one");
         end else if (gnt0 || gnt1) begin
            g = (gq.size() > 0) ? gq.pop_front() : -1;
            vectors++;
            if (int'(gnt1) != g) begin
               miscompares++;
               $display("FAIL rr_order got grant %0d want %0d", gnt1, g);
            end
            if (gnt0) begin
               n0++;
               if (n0 < 2) begin data0 = d0[n0]; key0 = k0[n0]; end else req0 = 1'b0;
            end else begin
               n1++;
               if (n1 < 2) begin data1 = d1[n1]; key1 = k1[n1]; end else req1 = 1'b0;
            end
         end
         if (rsp_valid) begin
            e = exp_q.pop_front();
            got++;
            vectors++;
            if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
               miscompares++;
               $display("FAIL rr_rsp got id=%0d data=%h err=%0d want id=%0d data=%h err=%0d",
                        rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      vectors++;
      if (got != 4) begin
         miscompares++;
         $display("FAIL rr_timeout got %0d responses want 4", got);
         exp_q.delete();
      end
   endtask

   task automatic test_single_encrypt();
      int cyc;
      rsp_t e;
      @(negedge clk_master);
      req0 = 1'b1; mode0 = 1'b1; data0 = VEC_D; key0 = VEC_K; rsp_ready = 1'b1;
      exp_q.push_back('{1'b0, VEC_C, 1'b0});
      @(negedge clk_master);
      vectors++;
      if ({gnt0, gnt1} !== 2'b10) begin
         miscompares++;
         $display("FAIL enc_gnt_latency got gnt0=%0d gnt1=%0d want 1 0", gnt0, gnt1);
      end
      vectors++;
      if ({eng_rst, eng_sel_encrypt, eng_sel_decrypt} !== 3'b110 || eng_data !== VEC_D || eng_key !== VEC_K) begin
         miscompares++;
         $display("FAIL enc_load got ctl=%b data=%h key=%h want 110 %h %h",
                  {eng_rst, eng_sel_encrypt, eng_sel_decrypt}, eng_data, eng_key, VEC_D, VEC_K);
      end
      req0 = 1'b0; data0 = rnd128(); key0 = rnd128();
      @(negedge clk_master);
      vectors++;
      if (gnt0 !== 1'b0 || eng_rst !== 1'b0 || eng_data !== VEC_D) begin
         miscompares++;
         $display("FAIL enc_run_entry got gnt0=%0d eng_rst=%0d data=%h want 0 0 %h", gnt0, eng_rst, eng_data, VEC_D);
      end
      cyc = 0;
      while (!rsp_valid && cyc < 50) begin @(negedge clk_master); cyc++; end
      vectors++;
      if (!rsp_valid) begin
         miscompares++;
         $display("FAIL enc_rsp_wait got no rsp_valid want rsp_valid within 50 cycles");
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
            miscompares++;
            $display("FAIL enc_rsp got id=%0d data=%h err=%0d want id=%0d data=%h err=%0d",
                     rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
         end
      end
      @(negedge clk_master);
      vectors++;
      if (rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL enc_rsp_drop got rsp_valid=%0d want 0", rsp_valid);
      end
   endtask

   task automatic test_decrypt();
      int cyc;
      logic [127:0] d, k;
      rsp_t e;
      stray_done = 1'b1;
      @(negedge clk_master);
      stray_done = 1'b0;
      @(negedge clk_master);
      vectors++;
      if (rsp_valid !== 1'b0 || eng_rst !== 1'b1) begin
         miscompares++;
         $display("FAIL dec_stray_done got rsp_valid=%0d eng_rst=%0d want 0 1", rsp_valid, eng_rst);
      end
      d = rnd128(); k = rnd128();
      req1 = 1'b1; mode1 = 1'b0; data1 = d; key1 = k;
      exp_q.push_back('{1'b1, eng_fn(d, k, 1'b0), 1'b0});
      @(negedge clk_master);
      vectors++;
      if ({gnt0, gnt1, eng_sel_encrypt, eng_sel_decrypt} !== 4'b0101) begin
         miscompares++;
         $display("FAIL dec_load got gnt=%b sel=%b want 01 01", {gnt0, gnt1}, {eng_sel_encrypt, eng_sel_decrypt});
      end
      req1 = 1'b0;
      cyc = 0;
      @(negedge clk_master);
      while (!rsp_valid && cyc < 50) begin
         vectors++;
         if ({eng_rst, eng_sel_encrypt, eng_sel_decrypt} !== 3'b001) begin
            miscompares++;
            $display("FAIL dec_run_sel got ctl=%b want 001", {eng_rst, eng_sel_encrypt, eng_sel_decrypt});
         end
         @(negedge clk_master);
         cyc++;
      end
      vectors++;
      if (!rsp_valid) begin
         miscompares++;
         $display("FAIL dec_rsp_wait got no rsp_valid want rsp_valid within 50 cycles");
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
            miscompares++;
            $display("FAIL dec_rsp got id=%0d data=%h err=%0d want id=%0d data=%h err=%0d",
                     rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
         end
      end
      @(negedge clk_master);
   endtask

   task automatic test_resp_stall();
      int cyc, bad;
      logic [127:0] d, k;
      rsp_t e;
      rsp_ready = 1'b0;
      d = rnd128(); k = rnd128();
      req0 = 1'b1; mode0 = 1'b1; data0 = d; key0 = k;
      exp_q.push_back('{1'b0, eng_fn(d, k, 1'b1), 1'b0});
      cyc = 0;
      do begin @(negedge clk_master); cyc++; end while (!gnt0 && cyc < 10);
      req0 = 1'b0;
      while (!rsp_valid && cyc < 60) begin @(negedge clk_master); cyc++; end
      d = rnd128(); k = rnd128();
      req1 = 1'b1; mode1 = 1'b1; data1 = d; key1 = k;
      exp_q.push_back('{1'b1, eng_fn(d, k, 1'b1), 1'b0});
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_master);
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_q[0].data || eng_rst !== 1'b1 || {gnt0, gnt1} !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_hold cycle %0d got valid=%0d data=%h eng_rst=%0d gnt=%b want 1 %h 1 00",
                     i, rsp_valid, rsp_data, eng_rst, {gnt0, gnt1}, exp_q[0].data);
         end
      end
      rsp_ready = 1'b1;
      e = exp_q.pop_front();
      vectors++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
         miscompares++;
         $display("FAIL stall_rsp got valid=%0d id=%0d data=%h err=%0d want 1 %0d %h %0d",
                  rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
      end
      @(negedge clk_master);
      vectors++;
      if (rsp_valid !== 1'b0 || gnt1 !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_idle got valid=%0d gnt1=%0d want 0 0", rsp_valid, gnt1);
      end
      @(negedge clk_master);
      vectors++;
      if (gnt1 !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_regrant got gnt1=%0d want 1", gnt1);
      end
      req1 = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 50) begin @(negedge clk_master); cyc++; end
      vectors++;
      e = exp_q.pop_front();
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
         miscompares++;
         $display("FAIL stall_next_rsp got valid=%0d id=%0d data=%h want 1 %0d %h",
                  rsp_valid, rsp_id, rsp_data, e.id, e.data);
      end
      @(negedge clk_master);
   endtask

   task automatic test_reset_mid_run();
      int cyc, bad;
      logic [127:0] d, k;
      rsp_t e;
      eng_hang = 1'b1;
      req0 = 1'b1; mode0 = 1'b1; data0 = rnd128(); key0 = rnd128();
      cyc = 0;
      do begin @(negedge clk_master); cyc++; end while (!gnt0 && cyc < 10);
      req0 = 1'b0;
      repeat (3) @(negedge clk_master);
      vectors++;
      if (eng_rst !== 1'b0) begin
         miscompares++;
         $display("FAIL rstrun_in_run got eng_rst=%0d want 0", eng_rst);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({gnt0, gnt1, rsp_valid, rsp_err, rsp_id, eng_rst, eng_sel_encrypt, eng_sel_decrypt} !== 8'b00000100 ||
          eng_data !== 128'h0 || eng_key !== '0 || rsp_data !== 128'h0) begin
         miscompares++;
         $display("FAIL rstrun_async got flags=%b eng_data=%h want 00000100 and zero buses",
                  {gnt0, gnt1, rsp_valid, rsp_err, rsp_id, eng_rst, eng_sel_encrypt, eng_sel_decrypt}, eng_data);
      end
      @(negedge clk_master);
      rst = 1'b0; eng_hang = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_master);
         if (rsp_valid || gnt0 || gnt1) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL rstrun_no_resp got %0d active cycles want 0", bad);
      end
      d = rnd128(); k = rnd128();
      req0 = 1'b1; data0 = d; key0 = k;
      exp_q.push_back('{1'b0, eng_fn(d, k, 1'b1), 1'b0});
      @(negedge clk_master);
      vectors++;
      if ({gnt0, gnt1} !== 2'b10) begin
         miscompares++;
         $display("FAIL rstrun_regrant got gnt=%b want 10", {gnt0, gnt1});
      end
      req0 = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 50) begin @(negedge clk_master); cyc++; end
      vectors++;
      e = exp_q.pop_front();
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
         miscompares++;
         $display("FAIL rstrun_rsp got valid=%0d id=%0d data=%h want 1 %0d %h",
                  rsp_valid, rsp_id, rsp_data, e.id, e.data);
      end
      @(negedge clk_master);
   endtask

`ifdef AES_TIMEOUT_EN
   task automatic test_timeout();
      int cyc, run_cnt;
      logic [127:0] d, k;
      rsp_t e;
      for (int v = 0; v < 2; v++) begin
         eng_hang = 1'b1;
         d = rnd128(); k = rnd128();
         req0 = 1'b1; mode0 = 1'b1; data0 = d; key0 = k;
         if (v == 0) exp_q.push_back('{1'b0, 128'h0, 1'b1});
         else        exp_q.push_back('{1'b0, eng_fn(d, k, 1'b1), 1'b0});
         cyc = 0;
         do begin @(negedge clk_master); cyc++; end while (!gnt0 && cyc < 10);
         req0 = 1'b0;
         run_cnt = 0;
         cyc = 0;
         while (cyc < 100) begin
            @(negedge clk_master);
            cyc++;
            stray_done = 1'b0;
            if (rsp_valid) break;
            if (!eng_rst) run_cnt++;
            if (v == 1 && run_cnt == 16) stray_done = 1'b1;
         end
         stray_done = 1'b0;
         vectors++;
         if (run_cnt != 16) begin
            miscompares++;
            $display("FAIL timeout_cycles variant %0d got %0d RUN cycles want 16", v, run_cnt);
         end
         vectors++;
         e = exp_q.pop_front();
         if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, e.data, e.err}) begin
            miscompares++;
            $display("FAIL timeout_rsp variant %0d got valid=%0d data=%h err=%0d want 1 %h %0d",
                     v, rsp_valid, rsp_data, rsp_err, e.data, e.err);
         end
         eng_hang = 1'b0;
         @(negedge clk_master);
      end
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL global_watchdog got simulation still running want finished");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
      data0 = '0; data1 = '0; key0 = '0; key1 = '0; rsp_ready = 1'b1;
      stray_done = 1'b0; eng_hang = 1'b0;
      test_reset();
      test_round_robin();
      test_single_encrypt();
      test_decrypt();
      test_resp_stall();
      test_reset_mid_run();
`ifdef AES_TIMEOUT_EN
      test_timeout();
`endif
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
